// File: rtl/config_pkg.sv
// Minimal core-configuration and EX-stage FU types shared by the shadow
// register restore unit and its environment.
package config_pkg;

  typedef struct packed {
    int unsigned XLEN;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{XLEN: 32'd32};

  typedef logic [63:0] xlen_t;

  typedef enum logic [3:0] {
    NONE,
    LOAD,
    STORE,
    ALU,
    CTRL_FLOW,
    MULT,
    CSR
  } fu_t;

  typedef enum logic [7:0] {
    ADD,
    LW,
    LHSR
  } fu_op;

  typedef struct packed {
    fu_t        fu;
    fu_op       operation;
    xlen_t      operand_a;
    xlen_t      operand_b;
    xlen_t      imm;
    logic [2:0] trans_id;
  } fu_data_t;

endpackage

// File: rtl/shadow_register_restore.sv
// Restores the shadow register file from a stack frame on interrupt return:
// one LHSR load per register, lowest address into index 0, one load in flight.
module shadow_register_restore #(
  parameter config_pkg::cva6_cfg_t CVA6Cfg          = config_pkg::cva6_cfg_empty,
  parameter type                   fu_data_t        = logic,
  parameter int unsigned           ADDR_WIDTH       = 6,
  parameter int unsigned           DATA_WIDTH       = 32,
  parameter int unsigned           NUM_SHADOW_SAVES = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  shadow_restore_i,
  input  logic [DATA_WIDTH-1:0] shadow_sp_i,
  output logic                  restore_ready_o,
  output logic                  restore_done_o,
  output logic                  restore_error_o,
  output logic [DATA_WIDTH-1:0] shadow_sp_o,
  output logic                  shlu_valid_o,
  output fu_data_t              shlu_fu_data_o,
  input  logic                  lsu_ready_i,
  input  logic                  shlu_load_valid_i,
  input  logic [DATA_WIDTH-1:0] shlu_load_data_i,
  input  logic                  shlu_load_ex_i,
  output logic                  shadow_reg_we_o,
  output logic [ADDR_WIDTH-1:0] shadow_reg_waddr_o,
  output logic [DATA_WIDTH-1:0] shadow_reg_wdata_o
);

  localparam logic [DATA_WIDTH-1:0] STRIDE   = DATA_WIDTH'(CVA6Cfg.XLEN / 8);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_SHADOW_SAVES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    load_ok, load_err;
  config_pkg::fu_data_t    fu_data;

  // Load responses only count while a load is actually outstanding.
  assign load_ok  = (state_q == WAIT) && shlu_load_valid_i && !shlu_load_ex_i;
  assign load_err = (state_q == WAIT) && shlu_load_valid_i &&  shlu_load_ex_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (shadow_restore_i) begin
          addr_d  = shadow_sp_i;
          cnt_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (lsu_ready_i) state_d = WAIT;
      end
      WAIT: begin
        if (load_err) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (load_ok) begin
          if (cnt_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            addr_d  = addr_q + STRIDE;
            state_d = ISSUE;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    restore_ready_o    = (state_q == IDLE);
    restore_done_o     = 1'b0;
    restore_error_o    = 1'b0;
    shadow_sp_o        = '0;
    shlu_valid_o       = 1'b0;
    shadow_reg_we_o    = 1'b0;
    shadow_reg_waddr_o = cnt_q;
    shadow_reg_wdata_o = shlu_load_data_i;
    unique case (state_q)
      ISSUE: shlu_valid_o = lsu_ready_i;
      WAIT: begin
        shadow_reg_we_o = load_ok;
        restore_error_o = load_err;
      end
      DONE: begin
        restore_done_o = 1'b1;
        shadow_sp_o    = addr_q + STRIDE;
      end
      default: ;
    endcase
  end

  // The request descriptor is constant apart from the frame address.
  always_comb begin
    fu_data           = '0;
    fu_data.fu        = config_pkg::LOAD;
    fu_data.operation = config_pkg::LHSR;
    fu_data.operand_a = config_pkg::xlen_t'(addr_q);
    fu_data.operand_b = '0;
    fu_data.imm       = '0;
    fu_data.trans_id  = '0;
  end

  assign shlu_fu_data_o = fu_data_t'(fu_data);

endmodule

// File: doc/shadow_register_restore.md
SHADOW_REGISTER_RESTORE -- requirements
Module: shadow_register_restore

Interface
REQ-001 SHALL have parameter CVA6Cfg, default config_pkg::cva6_cfg_empty, core configuration (XLEN used for stride).
REQ-002 SHALL have parameter fu_data_t, default logic, EX-stage FU data type.
REQ-003 SHALL have parameter ADDR_WIDTH, default 6, shadow register index width.
REQ-004 SHALL have parameter DATA_WIDTH, default 32, shadow register data width.
REQ-005 SHALL have parameter NUM_SHADOW_SAVES, default 16, registers restored per frame.
REQ-006 SHALL have port clk_i  input  1  clock; all state updates on its rising edge.
REQ-007 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port shadow_restore_i  input  1  restore request (interrupt return).
REQ-009 SHALL have port shadow_sp_i  input  DATA_WIDTH  stack pointer addressing the lowest saved word of the frame.
REQ-010 SHALL have port restore_ready_o  output  1  high when idle and a request is accepted.
REQ-011 SHALL have port restore_done_o  output  1  one-cycle pulse on successful completion.
REQ-012 SHALL have port restore_error_o  output  1  one-cycle pulse on load exception abort.
REQ-013 SHALL have port shadow_sp_o  output  DATA_WIDTH  frame base plus NUM_SHADOW_SAVES*XLEN/8, valid with restore_done_o.
REQ-014 SHALL have port shlu_valid_o  output  1  load request to LSU valid.
REQ-015 SHALL have port shlu_fu_data_o  output  fu_data_t  load request FU data.
REQ-016 SHALL have port lsu_ready_i  input  1  LSU accepts an instruction this cycle.
REQ-017 SHALL have port shlu_load_valid_i  input  1  load result valid.
REQ-018 SHALL have port shlu_load_data_i  input  DATA_WIDTH  load result data.
REQ-019 SHALL have port shlu_load_ex_i  input  1  load raised an exception; qualified by shlu_load_valid_i.
REQ-020 SHALL have port shadow_reg_we_o  output  1  shadow register write enable.
REQ-021 SHALL have port shadow_reg_waddr_o  output  ADDR_WIDTH  shadow register write index.
REQ-022 SHALL have port shadow_reg_wdata_o  output  DATA_WIDTH  shadow register write data.

Function
REQ-023 SHALL implement states IDLE, ISSUE, WAIT, DONE; one load outstanding at most.
REQ-024 IDLE: restore_ready_o=1; on shadow_restore_i SHALL load addr_q=shadow_sp_i, cnt_q=0, go ISSUE next cycle.
REQ-025 shadow_restore_i outside IDLE SHALL be ignored (no queuing).
REQ-026 ISSUE: shlu_valid_o SHALL equal lsu_ready_i combinationally; when lsu_ready_i=1 go WAIT.
REQ-027 shlu_fu_data_o SHALL drive fu=LOAD, operation=LHSR, operand_a=addr_q, operand_b=0, imm=0, trans_id=0 in all states.
REQ-028 WAIT: on shlu_load_valid_i=1 and shlu_load_ex_i=0, SHALL assert shadow_reg_we_o same cycle with waddr=cnt_q, wdata=shlu_load_data_i.
REQ-029 After such write: if cnt_q==NUM_SHADOW_SAVES-1 go DONE; else cnt_q+1, addr_q+XLEN/8, go ISSUE.
REQ-030 Register order SHALL be index 0 at lowest address ascending to index NUM_SHADOW_SAVES-1, inverse of save order.
REQ-031 WAIT with shlu_load_valid_i=1 and shlu_load_ex_i=1: no write, restore_error_o=1 that cycle, go IDLE, cnt_q=0.
REQ-032 DONE: restore_done_o=1 for exactly one cycle, shadow_sp_o=addr_q+XLEN/8, then IDLE.
REQ-033 Address arithmetic SHALL be DATA_WIDTH bits, wrapping modulo 2^DATA_WIDTH.
REQ-034 shlu_valid_o and shadow_reg_we_o SHALL be 0 in IDLE and DONE; shlu_valid_o 0 in WAIT.
REQ-035 shadow_reg_we_o SHALL never assert more than NUM_SHADOW_SAVES times per request.
REQ-036 shlu_load_valid_i outside WAIT SHALL be ignored.

Reset
REQ-037 On rst_ni=0 SHALL asynchronously enter IDLE, addr_q=0, cnt_q=0, aborting any restore in progress.
REQ-038 In reset: restore_ready_o=1, restore_done_o=0, restore_error_o=0, shlu_valid_o=0, shadow_reg_we_o=0, shadow_sp_o=0.

Verification
REQ-039 Request with sp=0x1000, lsu_ready_i=1, load data=0xA0+i one cycle after issue -> 16 writes idx 0..15 data 0xA0..0xAF, addresses 0x1000..0x103C step 4, done pulse, shadow_sp_o=0x1040.
REQ-040 lsu_ready_i held 0 for 5 cycles in ISSUE -> shlu_valid_o stays 0, no state advance, then normal completion.
REQ-041 Exception on 3rd load (idx 2) -> writes only idx 0,1, restore_error_o one cycle, IDLE, no done pulse.
REQ-042 shadow_restore_i re-asserted during WAIT -> ignored, exactly 16 writes, single done pulse.
REQ-043 sp=0xFFFFFFF8 -> load addresses wrap to 0x00000000 after 0xFFFFFFFC; shadow_sp_o=0x38.
REQ-044 rst_ni low during idx 7 WAIT -> immediate IDLE, outputs at reset values, subsequent request restarts at idx 0.
